// File: rtl/vram_pkg.sv
// Shared widths, defaults and FSM state type for the VRAM pixel writer.
package vram_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned       H_RES_DEF       = 512;
  localparam int unsigned       V_RES_DEF       = 512;
  localparam logic [DATA_W-1:0] CLEAR_COLOR_DEF = 8'h00;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_e;

endpackage

// File: rtl/pix_addr_map.sv
// Range check and linear framebuffer address for a pixel coordinate.
module pix_addr_map
  import vram_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic [9:0]        pix_x_i,
  input  logic [9:0]        pix_y_i,
  output logic              in_range_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Pure combinational mapping: y*H_RES + x, valid only when both coordinates are in range.
  always_comb begin
    in_range_o = (32'(pix_x_i) < H_RES) && (32'(pix_y_i) < V_RES);
    addr_o     = ADDR_W'(pix_y_i) * ADDR_W'(H_RES) + ADDR_W'(pix_x_i);
  end

endmodule

// File: rtl/vram_pixel_writer.sv
// Pixel-stream to VRAM writer with full-framebuffer clear sweeps after reset or on request.
module vram_pixel_writer
  import vram_pkg::*;
#(
  parameter int unsigned       H_RES       = H_RES_DEF,
  parameter int unsigned       V_RES       = V_RES_DEF,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              clear_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              clear_done,
  output logic              frame_done,
  output logic [7:0]        drop_cnt
);

  // One extra bit so the counters can hold H_RES*V_RES itself.
  localparam int unsigned    CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] Total   = CntW'(H_RES * V_RES);
  localparam logic [CntW-1:0] LastCnt = Total - CntW'(1);

  state_e            state_q;
  logic [CntW-1:0]   clr_addr_q;
  logic [CntW-1:0]   pcnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              clear_done_q;
  logic              frame_done_q;
  logic [7:0]        drop_q;

  logic              in_range;
  logic [ADDR_W-1:0] map_addr;

  pix_addr_map #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_pix_addr_map (
    .pix_x_i   (pix_x),
    .pix_y_i   (pix_y),
    .in_range_o(in_range),
    .addr_o    (map_addr)
  );

  // Ready is a pure function of state so upstream sees no combinational loop.
  assign pix_ready = (state_q == S_RUN);

  // Sweep/run FSM with registered VRAM port, pulses and drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      pcnt_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      clear_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      we_q         <= 1'b0;
      clear_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          if (clear_done_q) begin
            // Pulse has been shown; only now open the pixel port.
            state_q    <= S_RUN;
            clr_addr_q <= '0;
          end else if (clr_addr_q == Total) begin
            clear_done_q <= 1'b1;
            pcnt_q       <= '0;
          end else begin
            we_q       <= 1'b1;
            addr_q     <= clr_addr_q[ADDR_W-1:0];
            wdata_q    <= CLEAR_COLOR;
            clr_addr_q <= clr_addr_q + CntW'(1);
          end
        end
        S_RUN: begin
          if (pix_valid) begin
            if (in_range) begin
              we_q    <= 1'b1;
              addr_q  <= map_addr;
              wdata_q <= pix_data;
              if (pcnt_q == LastCnt) begin
                frame_done_q <= 1'b1;
                pcnt_q       <= '0;
              end else begin
                pcnt_q <= pcnt_q + CntW'(1);
              end
            end else if (drop_q != 8'hFF) begin
              drop_q <= drop_q + 8'd1;
            end
          end
          // A pixel accepted alongside the request is written first, sweep follows.
          if (clear_req) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
          end
        end
      endcase
    end
  end

  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign clear_done = clear_done_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Scoreboard bench for vram_pixel_writer with an 8x4 framebuffer.
module tb_vram_pixel_writer;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned N = H * V;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [7:0]  pix_data = '0;
  logic        clear_req = 1'b0;
  logic        vram_we;
  logic [17:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        clear_done;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  typedef struct {
    logic [17:0] addr;
    logic [7:0]  data;
    logic        fd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail = 0;

  vram_pixel_writer #(
    .H_RES      (H),
    .V_RES      (V),
    .CLEAR_COLOR(8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .clear_req (clear_req),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .clear_done(clear_done),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [17:0] a, input logic [7:0] d, input logic fd);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.fd   = fd;
    exp_q.push_back(w);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < int'(N); i++) push(18'(i), 8'h00, 1'b0);
  endtask

  // Run through a sweep; optionally fire a second clear_req and a pixel mid-sweep.
  task automatic run_sweep(input int exp_cyc, input bit inject);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      if (inject && n == 5) begin
        clear_req = 1'b1;
        pix_valid = 1'b1;
        pix_x     = 10'd2;
        pix_y     = 10'd2;
        pix_data  = 8'h77;
      end
      tick();
      n++;
      clear_req = 1'b0;
      pix_valid = 1'b0;
      if (clear_done === 1'b1) seen = 1'b1;
      else check("ready_low_in_sweep", 32'(pix_ready), 32'd0);
    end
    check("clear_done_cycle", n, exp_cyc);
    tick();
    check("ready_after_clear", 32'(pix_ready), 32'd1);
    check("clear_done_pulse_len", 32'(clear_done), 32'd0);
  endtask

  // Monitor: every VRAM write is matched against the next expected entry.
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 vram_addr, vram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (vram_addr !== mon_e.addr || vram_wdata !== mon_e.data || frame_done !== mon_e.fd) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h fd=%b, required addr=%0d data=%h fd=%b",
                   vram_addr, vram_wdata, frame_done, mon_e.addr, mon_e.data, mon_e.fd);
        end
      end
    end else if (frame_done === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_frame_done: got 1 without write, required 0");
    end
  end

  initial begin
    int k;
    // Reset state
    repeat (3) tick();
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_wdata", 32'(vram_wdata), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);

    // Initial sweep after reset release: 32 writes, then clear_done, then ready
    push_sweep();
    reset_n = 1'b1;
    run_sweep(33, 1'b0);

    // 33 back-to-back in-range writes: frame_done on the 32nd only
    for (int i = 0; i < 33; i++) begin
      push(18'(i % 32), 8'(i * 7 + 1), (i == 31));
      pix_valid = 1'b1;
      pix_x     = 10'(i % 8);
      pix_y     = 10'((i / 8) % 4);
      pix_data  = 8'(i * 7 + 1);
      tick();
    end
    pix_valid = 1'b0;

    // Single write x=3,y=2 -> address 19
    push(18'd19, 8'hA5, 1'b0);
    pix_valid = 1'b1;
    pix_x     = 10'd3;
    pix_y     = 10'd2;
    pix_data  = 8'hA5;
    tick();
    pix_valid = 1'b0;
    check("wr19_we", 32'(vram_we), 32'd1);
    check("wr19_addr", 32'(vram_addr), 32'd19);

    // Out-of-range on each axis
    pix_valid = 1'b1;
    pix_x = 10'd8;  pix_y = 10'd0; pix_data = 8'h11;
    tick();
    pix_x = 10'd0;  pix_y = 10'd4; pix_data = 8'h22;
    tick();
    pix_valid = 1'b0;
    check("drop_two", 32'(drop_cnt), 32'd2);
    check("addr_stable", 32'(vram_addr), 32'd19);
    pix_valid = 1'b1;
    for (int i = 0; i < 298; i++) begin
      pix_x = (i % 2 == 0) ? 10'd1023 : 10'd5;
      pix_y = (i % 2 == 0) ? 10'd0 : 10'd600;
      tick();
    end
    pix_valid = 1'b0;
    check("drop_saturated", 32'(drop_cnt), 32'd255);

    // clear_req with a simultaneous pixel: pixel first, then sweep; mid-sweep clear_req ignored
    push(18'd9, 8'h3C, 1'b0);
    push_sweep();
    clear_req = 1'b1;
    pix_valid = 1'b1;
    pix_x = 10'd1; pix_y = 10'd1; pix_data = 8'h3C;
    tick();
    clear_req = 1'b0;
    pix_valid = 1'b0;
    check("ready_low_after_req", 32'(pix_ready), 32'd0);
    run_sweep(33, 1'b1);

    // Reset while the sweep is at address 10
    push_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    k = 0;
    while (k < 60 && !(vram_we === 1'b1 && vram_addr == 18'd10)) begin
      tick();
      k++;
    end
    check("reached_addr10", 32'(k < 60), 32'd1);
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    check("midrst_we", 32'(vram_we), 32'd0);
    check("midrst_addr", 32'(vram_addr), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    push_sweep();
    reset_n = 1'b1;
    run_sweep(33, 1'b0);

    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_pixel_writer.md
VRAM_PIXEL_WRITER -- requirements
Module: vram_pixel_writer

Interface
REQ-001 SHALL have parameter H_RES, default 512, framebuffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 512, framebuffer height in pixels.
REQ-003 SHALL have parameter CLEAR_COLOR, default 8'h00, fill value for clear sweeps.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, reset: one clock; synchronous, active-low.
REQ-006 SHALL have port pix_valid, input, 1, a pixel write is offered.
REQ-007 SHALL have port pix_ready, output, 1, the offered pixel is accepted this cycle.
REQ-008 SHALL have port pix_x, input, 10, pixel column.
REQ-009 SHALL have port pix_y, input, 10, pixel row.
REQ-010 SHALL have port pix_data, input, 8, pixel colour.
REQ-011 SHALL have port clear_req, input, 1, single-cycle request for a full framebuffer clear.
REQ-012 SHALL have port vram_we, output, 1, VRAM write strobe.
REQ-013 SHALL have port vram_addr, output, 18, VRAM word address.
REQ-014 SHALL have port vram_wdata, output, 8, VRAM write data.
REQ-015 SHALL have port clear_done, output, 1, one-cycle pulse when a clear sweep ends.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse after H_RES*V_RES in-range pixel writes.
REQ-017 SHALL have port drop_cnt, output, 8, saturating count of discarded out-of-range pixels.

Function
REQ-018 SHALL implement FSM states S_CLEAR and S_RUN.
REQ-019 SHALL assert pix_ready only in S_RUN; a transfer is pix_valid & pix_ready.
REQ-020 SHALL, for an in-range transfer (pix_x<H_RES, pix_y<V_RES), drive vram_we=1, vram_addr=pix_y*H_RES+pix_x and vram_wdata=pix_data on the next cycle.
REQ-021 SHALL, for an out-of-range transfer, accept it without a VRAM write and increment drop_cnt, saturating at 255.
REQ-022 SHALL, in S_CLEAR, write CLEAR_COLOR to addresses 0 through H_RES*V_RES-1, one per cycle, in ascending order.
REQ-023 SHALL, after the last clear write, pulse clear_done for one cycle, enter S_RUN, and zero the pixel counter.
REQ-024 SHALL, on clear_req in S_RUN, enter S_CLEAR next cycle; a pixel accepted in the same cycle as clear_req SHALL still be written before the first clear write.
REQ-025 SHALL ignore clear_req while in S_CLEAR.
REQ-026 SHALL count in-range writes; on the write that makes the count H_RES*V_RES it SHALL pulse frame_done in the same cycle as that vram_we and wrap the count to 0.
REQ-027 SHALL keep vram_addr and vram_wdata stable and vram_we=0 on cycles with no write.
REQ-028 SHALL generate all outputs from registers (no combinational input-to-output paths) except pix_ready, which SHALL depend on the state only.

Reset
REQ-029 SHALL, while reset_n=0 at a clk edge, set vram_we=0, vram_addr=0, vram_wdata=0, clear_done=0, frame_done=0, drop_cnt=0, the pixel counter to 0, and the clear address to 0.
REQ-030 SHALL enter S_CLEAR on the first cycle after reset_n rises, so the framebuffer is initialised after every reset.
REQ-031 SHALL abandon any sweep or pending write when reset_n=0 mid-operation and restart the sweep from address 0.

Structure
REQ-032 SHALL place ADDR_W=18, DATA_W=8, the FSM state enum, and the default H_RES, V_RES and CLEAR_COLOR in shared package vram_pkg.
REQ-033 SHALL use one combinational sub-module, pix_addr_map, for the range check and the y*H_RES+x address computation.

Verification (H_RES=8, V_RES=4)
REQ-034 Reset release -> 32 writes of 8'h00 at addresses 0..31 on consecutive cycles, then clear_done pulse, then pix_ready=1 on the next cycle.
REQ-035 Transfer x=3, y=2, data=8'hA5 -> next cycle vram_we=1, vram_addr=19, vram_wdata=8'hA5.
REQ-036 Transfers x=8,y=0 and x=0,y=4 -> no vram_we, drop_cnt=2; after 300 such transfers, drop_cnt=255.
REQ-037 32 back-to-back in-range transfers -> frame_done high together with the 32nd vram_we; the 33rd write does not pulse frame_done.
REQ-038 clear_req with a simultaneous transfer x=1,y=1,data=8'h3C -> write to address 9 first, then sweep 0..31; pix_ready=0 throughout the sweep; a second clear_req mid-sweep has no effect.
REQ-039 reset_n low at sweep address 10 -> sweep restarts at address 0, drop_cnt=0.
